adc_spi_responder: RTL
======================

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for adc_sck/adc_cs_n/adc_mosi (legal values 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all logic rising-edge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port adc_sck  input  1  SPI clock from initiator, asynchronous to clk, idle low (mode 0).
REQ-005 SHALL have port adc_cs_n  input  1  chip select, active-low, asynchronous.
REQ-006 SHALL have port adc_mosi  input  1  command data from initiator.
REQ-007 SHALL have port adc_miso  output  1  sample data to initiator.
REQ-008 SHALL have port ch_data  input  64  four 16-bit samples; channel n = ch_data[16n+15:16n].
REQ-009 SHALL have port last_cmd  output  8  command byte of last completed frame.
REQ-010 SHALL have port frame_done  output  1  one-clk pulse on good frame end.
REQ-011 SHALL have port frame_err  output  1  one-clk pulse on short frame.
REQ-012 SHALL have port busy  output  1  high while a frame is open.

Function
REQ-013 SHALL pass adc_sck, adc_cs_n, adc_mosi through SYNC_STAGES flops and detect SCK rise/fall and CS fall/rise on synchronized copies.
REQ-014 SHALL require SCK high and low time each >= SYNC_STAGES+2 clk; behaviour outside this is undefined.
REQ-015 SHALL implement states IDLE, CMD, GAP, DATA, TAIL; CS fall in any state -> CMD, bit counter cleared.
REQ-016 Frame = 32 SCK rising edges: edges 1-8 CMD (MOSI shifted in MSB first), 9-16 GAP, 17-32 DATA, beyond 32 TAIL.
REQ-017 SHALL sample MOSI on synchronized SCK rise; SHALL update adc_miso on synchronized SCK fall.
REQ-018 On 8th rise SHALL latch command and capture ch_data[cmd[1:0]] into a 16-bit shift register if cmd[7]=1, else 0x0000.
REQ-019 adc_miso SHALL be 0 in IDLE, CMD, GAP and TAIL; on the fall after 16th rise SHALL present data bit 15, then one bit lower per fall (bit 0 after 31st rise).
REQ-020 Extra SCK edges after 32nd SHALL be ignored (TAIL, miso 0).
REQ-021 CS rise with >= 32 rises -> last_cmd updated, frame_done pulses 1 clk after detected rise, state IDLE.
REQ-022 CS rise with < 32 rises -> frame_err pulses, last_cmd unchanged, state IDLE.
REQ-023 SCK edge and CS rise detected same clk: CS rise wins, edge discarded.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 ch_data changes after the 8th rise SHALL not affect the frame in progress.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, synchronizers to idle levels (sck 0, cs_n 1, mosi 0), adc_miso 0, last_cmd 0x00, frame_done 0, frame_err 0, busy 0, counters 0.
REQ-027 Reset mid-frame SHALL abort with no frame_done/frame_err; next frame requires a fresh CS fall.

Configuration
REQ-028 Macro ADC_RESP_TEST_PATTERN_EN defined: cmd[7]=1 and cmd[6]=1 SHALL return a 16-bit frame counter (counts frame_done pulses, wraps 0xFFFF->0x0000, reset 0) instead of ch_data.
REQ-029 Macro undefined: cmd[6] ignored, no frame counter logic present.

Verification
REQ-030 ch_data={DEF0,9ABC,5678,1234}, SCK=clk/10, cmd 0x81 -> MISO bits 17-32 = 0x5678, frame_done one pulse, last_cmd=0x81.
REQ-031 cmd 0x03 (invalid) -> data 0x0000, frame_done pulses, last_cmd=0x03.
REQ-032 CS released after 20 rises -> frame_err one pulse, last_cmd unchanged, busy 0, next full frame cmd 0x82 returns 0x9ABC.
REQ-033 rst_n low at 12th rise -> all outputs 0 asynchronously, no pulses, following 0x80 frame returns 0x1234.
REQ-034 36 SCK rises, cmd 0x80 -> data 0x1234 then MISO 0 for extra bits, frame_done pulses.
REQ-035 With ADC_RESP_TEST_PATTERN_EN, three frames cmd 0xC0 -> data 0x0000, 0x0001, 0x0002; without it -> 0x1234 each.

Source files
------------

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI mode-0 responder returning one of four 16-bit ADC
// samples. A frame is 32 SCK rises: 8 command bits, 8 gap bits, 16 data bits.
// All SPI inputs are oversampled in the clk domain through SYNC_STAGES flops.
// Optional feature: define ADC_RESP_TEST_PATTERN_EN to return a running
// frame counter for commands with cmd[7]=1 and cmd[6]=1.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_sck,
  input  logic        adc_cs_n,
  input  logic        adc_mosi,
  output logic        adc_miso,
  input  logic [63:0] ch_data,
  output logic [7:0]  last_cmd,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_TAIL = 3'd4;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  logic [2:0]  r_state;
  logic [5:0]  r_cnt;
  logic [7:0]  r_cmd_sh;
  logic [15:0] r_data_sh;
  logic        r_miso;
  logic [7:0]  r_last_cmd;
  logic        r_done;
  logic        r_err;

  logic        w_sck;
  logic        w_cs_n;
  logic        w_mosi;
  logic        w_sck_rise;
  logic        w_sck_fall;
  logic        w_cs_fall;
  logic        w_cs_rise;
  logic [7:0]  w_cmd_next;
  logic [15:0] w_capture;

`ifdef ADC_RESP_TEST_PATTERN_EN
  logic [15:0] r_frame_cnt;
`endif

  // Synchronizer chains plus one delayed copy of sck/cs_n for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], adc_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], adc_mosi};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_fall  = ~w_cs_n & r_cs_d;
  assign w_cs_rise  = w_cs_n & ~r_cs_d;
  assign w_cmd_next = {r_cmd_sh[6:0], w_mosi};

  // Word loaded into the data shifter on the 8th rise, chosen from the full command.
  always_comb begin
    w_capture = '0;
    if (w_cmd_next[7]) begin
`ifdef ADC_RESP_TEST_PATTERN_EN
      if (w_cmd_next[6]) w_capture = r_frame_cnt;
      else               w_capture = ch_data[{w_cmd_next[1:0], 4'b0000} +: 16];
`else
      w_capture = ch_data[{w_cmd_next[1:0], 4'b0000} +: 16];
`endif
    end
  end

  // Frame FSM: CS fall restarts, CS rise closes (and beats any same-cycle SCK edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cmd_sh   <= '0;
      r_data_sh  <= '0;
      r_miso     <= 1'b0;
      r_last_cmd <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_cs_fall) begin
        r_state   <= S_CMD;
        r_cnt     <= '0;
        r_cmd_sh  <= '0;
        r_data_sh <= '0;
        r_miso    <= 1'b0;
      end else if (w_cs_rise) begin
        if (r_state == S_TAIL) begin
          r_last_cmd <= r_cmd_sh;
          r_done     <= 1'b1;
        end else if (r_state != S_IDLE) begin
          r_err <= 1'b1;
        end
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_miso  <= 1'b0;
      end else begin
        case (r_state)
          S_CMD: begin
            if (w_sck_rise) begin
              r_cmd_sh <= w_cmd_next;
              r_cnt    <= r_cnt + 6'd1;
              if (r_cnt == 6'd7) begin
                r_data_sh <= w_capture;
                r_state   <= S_GAP;
              end
            end
          end
          S_GAP: begin
            if (w_sck_rise) begin
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == 6'd15) r_state <= S_DATA;
            end
          end
          S_DATA: begin
            if (w_sck_rise) begin
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == 6'd31) begin
                r_state <= S_TAIL;
                r_miso  <= 1'b0;
              end
            end else if (w_sck_fall) begin
              r_miso    <= r_data_sh[15];
              r_data_sh <= {r_data_sh[14:0], 1'b0};
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef ADC_RESP_TEST_PATTERN_EN
  // Counts completed good frames; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_frame_cnt <= '0;
    else if (r_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
`endif

  assign adc_miso   = r_miso;
  assign last_cmd   = r_last_cmd;
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule
